// File: rtl/hex_ram.sv
// Intel-HEX loader: parses an ASCII record stream into an internal byte RAM,
// reports every data write, flags format/checksum errors, and can dump the RAM.
module hex_ram #(
    parameter int RAM_AW = 10
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        EN,
    input  logic        C0,
    input  logic        DUMP_RAM,
    input  logic [7:0]  CHR,
    output logic        WR,
    output logic        ERR,
    output logic [15:0] ADDR,
    output logic [7:0]  DATA
);
    localparam int DEPTH = 1 << RAM_AW;
    localparam logic [RAM_AW-1:0] LAST = RAM_AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_ADR, S_TYPE, S_DATA, S_CSUM, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [3:0]        hi_q, hi_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        typ_q, typ_d;
    logic [15:0]       base_q, base_d;
    logic [7:0]        sum_q, sum_d;
    logic              err_d;
    logic              wr_d;
    logic [15:0]       waddr_d;
    logic [7:0]        wdata_d;
    logic              ram_we;
    logic [15:0]       addr_q;
    logic [7:0]        data_q;
    logic              dump_q;
    logic              src_ram_q;
    logic [RAM_AW-1:0] dump_cnt_q;
    logic [RAM_AW-1:0] dump_nxt;
    logic [7:0]        rd_data_p1;
    logic [4:0]        hex;
    logic [7:0]        byte_val;
    logic [7:0]        ram [DEPTH];

    // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

    assign hex      = hex_decode(CHR);
    assign byte_val = {hi_q, hex[3:0]};

    // Counter restarts on the DUMP_RAM rising edge and parks on the last address.
    assign dump_nxt = (DUMP_RAM && !dump_q) ? '0 :
                      (dump_cnt_q == LAST)  ? dump_cnt_q : dump_cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        typ_d   = typ_q;
        base_d  = base_q;
        sum_d   = sum_q;
        err_d   = ERR;
        wr_d    = 1'b0;
        waddr_d = addr_q;
        wdata_d = data_q;
        ram_we  = 1'b0;
        if (C0) begin
            err_d   = 1'b0;
            state_d = S_IDLE;
        end else if (!DUMP_RAM) begin
            case (state_q)
                S_IDLE: begin
                    if (EN && CHR == 8'h3A) begin
                        state_d = S_LEN;
                        phase_d = 1'b0;
                        cnt_d   = 8'd0;
                        sum_d   = 8'd0;
                    end
                end
                S_CHK: begin
                    if (sum_q != 8'd0) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (typ_q == 8'h01) begin
                        state_d = S_DONE;
                    end else if (EN && CHR == 8'h3A) begin
                        state_d = S_LEN;
                        phase_d = 1'b0;
                        cnt_d   = 8'd0;
                        sum_d   = 8'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DONE, S_ERROR: ;
                default: begin
                    if (EN) begin
                        if (!hex[4]) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end else if (!phase_q) begin
                            hi_d    = hex[3:0];
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            sum_d   = sum_q + byte_val;
                            cnt_d   = cnt_q + 8'd1;
                            case (state_q)
                                S_LEN: begin
                                    len_d   = byte_val;
                                    cnt_d   = 8'd0;
                                    state_d = S_ADR;
                                end
                                S_ADR: begin
                                    base_d = {base_q[7:0], byte_val};
                                    if (cnt_q[0]) begin
                                        cnt_d   = 8'd0;
                                        state_d = S_TYPE;
                                    end
                                end
                                S_TYPE: begin
                                    typ_d   = byte_val;
                                    cnt_d   = 8'd0;
                                    state_d = (len_q == 8'd0) ? S_CSUM : S_DATA;
                                end
                                S_DATA: begin
                                    if (typ_q == 8'h00) begin
                                        wr_d    = 1'b1;
                                        waddr_d = base_q + {8'd0, cnt_q};
                                        wdata_d = byte_val;
                                        ram_we  = ({16'd0, waddr_d} < 32'(DEPTH));
                                    end
                                    if (cnt_q + 8'd1 == len_q) begin
                                        cnt_d   = 8'd0;
                                        state_d = S_CSUM;
                                    end
                                end
                                S_CSUM:  state_d = S_CHK;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            ERR        <= 1'b0;
            WR         <= 1'b0;
            addr_q     <= 16'd0;
            data_q     <= 8'd0;
            dump_q     <= 1'b0;
            src_ram_q  <= 1'b0;
            dump_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ERR     <= err_d;
            dump_q  <= DUMP_RAM;
            if (DUMP_RAM) begin
                WR         <= 1'b0;
                dump_cnt_q <= dump_nxt;
                addr_q     <= 16'(dump_nxt);
                src_ram_q  <= 1'b1;
            end else begin
                WR <= wr_d;
                if (wr_d) begin
                    addr_q    <= waddr_d;
                    data_q    <= wdata_d;
                    src_ram_q <= 1'b0;
                end
            end
        end
    end

    // Record fields never need a reset value: each is loaded before it is used.
    always_ff @(posedge CLK) begin
        hi_d_reg: begin
            hi_q   <= hi_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            typ_q  <= typ_d;
            base_q <= base_d;
            sum_q  <= sum_d;
        end
    end

    // Sync-read port is fed the next dump address so DATA lines up with ADDR.
    always_ff @(posedge CLK) begin
        if (ram_we)
            ram[waddr_d[RAM_AW-1:0]] <= wdata_d;
        if (DUMP_RAM)
            rd_data_p1 <= ram[dump_nxt];
    end

    assign ADDR = addr_q;
    assign DATA = src_ram_q ? rd_data_p1 : data_q;

endmodule

// File: tb/tb_hex_ram.sv
// Bench for hex_ram: directed and random Intel-HEX records against a record-level
// model of the expected writes, error flag and RAM image, plus RAM dump sweeps.
`timescale 1ns/1ps
module tb_hex_ram;
    localparam int RAM_AW = 10;
    localparam int DEPTH  = 1 << RAM_AW;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        EN = 1'b0;
    logic        C0 = 1'b0;
    logic        DUMP_RAM = 1'b0;
    logic [7:0]  CHR = 8'h00;
    logic        WR;
    logic        ERR;
    logic [15:0] ADDR;
    logic [7:0]  DATA;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_ram [DEPTH];
    logic [7:0]  rec [256];
    logic [23:0] obs_q [$];
    logic [23:0] exp_q [$];
    bit          exp_err  = 1'b0;
    bit          exp_done = 1'b0;

    hex_ram #(.RAM_AW(RAM_AW)) dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .C0(C0), .DUMP_RAM(DUMP_RAM), .CHR(CHR),
        .WR(WR), .ERR(ERR), .ADDR(ADDR), .DATA(DATA)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (WR === 1'b1) obs_q.push_back({ADDR, DATA});

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lc);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (lc ? 8'h61 : 8'h41) + 8'(n - 4'd10);
    endfunction

    task automatic send_char(input logic [7:0] c, input int gap);
        repeat (gap) @(negedge CLK);
        EN  = 1'b1;
        CHR = c;
        @(negedge CLK);
        EN  = 1'b0;
        CHR = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit lc, input int gmax);
        send_char(hexc(b[7:4], lc), $urandom_range(0, gmax));
        send_char(hexc(b[3:0], lc), $urandom_range(0, gmax));
    endtask

    // Sends ':' LL AAAA TT rec[0..n-1] CC; a bad record carries CC+1.
    task automatic send_record(input logic [15:0] addr, input logic [7:0] typ, input int n,
                               input bit bad, input bit lc, input int gmax);
        logic [7:0] s;
        s = 8'(n) + addr[15:8] + addr[7:0] + typ;
        for (int i = 0; i < n; i++) s = s + rec[i];
        s = 8'h00 - s;
        if (bad) s = s + 8'h01;
        send_char(8'h3A, $urandom_range(0, gmax));
        send_byte(8'(n), lc, gmax);
        send_byte(addr[15:8], lc, gmax);
        send_byte(addr[7:0], lc, gmax);
        send_byte(typ, lc, gmax);
        for (int i = 0; i < n; i++) send_byte(rec[i], lc, gmax);
        send_byte(s, lc, gmax);
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        if (32'(a) < DEPTH) model_ram[a[RAM_AW-1:0]] = d;
    endtask

    // Loader rules: only type 00 writes, nothing is accepted after an error or EOF record.
    task automatic expect_record(input logic [15:0] addr, input logic [7:0] typ, input int n,
                                 input bit bad);
        if (!exp_err && !exp_done) begin
            if (typ == 8'h00)
                for (int i = 0; i < n; i++) expect_wr(addr + 16'(i), rec[i]);
            if (bad) exp_err = 1'b1;
            else if (typ == 8'h01) exp_done = 1'b1;
        end
    endtask

    task automatic check_writes(input string tag);
        int m;
        repeat (2) @(negedge CLK);
        chk({tag, "_wr_count"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk({tag, "_wr_addr_data"}, obs_q[i], exp_q[i]);
        chk({tag, "_err"}, ERR, exp_err);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic c0_pulse();
        C0 = 1'b1;
        @(negedge CLK);
        C0 = 1'b0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        chk("c0_clears_err", ERR, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rt;
        int          rn;
        bit          rb;

        // Reset held, then idle junk ignored.
        repeat (3) @(negedge CLK);
        chk("rst_wr", WR, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_addr", ADDR, 16'h0000);
        chk("rst_data", DATA, 8'h00);
        CLR = 1'b1;
        send_str("G\r\n ");
        chk("idle_wr", WR, 1'b0);
        chk("idle_err", ERR, 1'b0);
        chk("idle_addr", ADDR, 16'h0000);
        chk("idle_data", DATA, 8'h00);
        check_writes("idle");

        // Fill the whole RAM so every dumped byte has a known value.
        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int i = 0; i < 16; i++) rec[i] = 8'($urandom);
            rb = 1'($urandom);
            expect_record(16'(k * 16), 8'h00, 16, 1'b0);
            send_record(16'(k * 16), 8'h00, 16, 1'b0, rb, 1);
            check_writes("fill");
        end

        // Directed good record.
        send_str(":0300300002337A1E");
        expect_wr(16'h0030, 8'h02);
        expect_wr(16'h0031, 8'h33);
        expect_wr(16'h0032, 8'h7A);
        check_writes("good_rec");

        // Bad checksum: same writes, ERR exactly one cycle after the last character.
        send_str(":0300300002337A1F");
        chk("bad_cs_err_early", ERR, 1'b0);
        @(negedge CLK);
        chk("bad_cs_err_set", ERR, 1'b1);
        expect_wr(16'h0030, 8'h02);
        expect_wr(16'h0031, 8'h33);
        expect_wr(16'h0032, 8'h7A);
        exp_err = 1'b1;
        check_writes("bad_cs");
        send_str(":0300300002337A1E");
        check_writes("after_err_blocked");
        c0_pulse();
        send_str(":02004000ABCD46");
        expect_wr(16'h0040, 8'hAB);
        expect_wr(16'h0041, 8'hCD);
        check_writes("after_c0");

        // EOF record, then data ignored; uppercase then lowercase.
        send_str(":00000001FF");
        exp_done = 1'b1;
        check_writes("eof_upper");
        send_str(":0300300002337A1E");
        check_writes("done_ignores");
        c0_pulse();
        send_str(":00000001ff");
        exp_done = 1'b1;
        check_writes("eof_lower");
        send_str(":02004000abcd46");
        check_writes("done_ignores_lc");
        c0_pulse();
        send_str(":0300300002337a1e");
        expect_wr(16'h0030, 8'h02);
        expect_wr(16'h0031, 8'h33);
        expect_wr(16'h0032, 8'h7A);
        check_writes("lower_data");

        // Non-hex inside the address field.
        send_str(":0300G");
        chk("nonhex_err", ERR, 1'b1);
        exp_err = 1'b1;
        check_writes("nonhex");
        c0_pulse();

        // Boundaries: across the RAM top, 16-bit wrap, non-data type, empty record.
        rec[0] = 8'h11; rec[1] = 8'h22; rec[2] = 8'h33; rec[3] = 8'h44;
        expect_record(16'h03FE, 8'h00, 4, 1'b0);
        send_record(16'h03FE, 8'h00, 4, 1'b0, 1'b0, 0);
        check_writes("ram_top");
        rec[0] = 8'h5A; rec[1] = 8'hC3; rec[2] = 8'h99;
        expect_record(16'hFFFE, 8'h00, 3, 1'b0);
        send_record(16'hFFFE, 8'h00, 3, 1'b0, 1'b1, 0);
        check_writes("addr_wrap");
        expect_record(16'h0010, 8'h02, 2, 1'b0);
        send_record(16'h0010, 8'h02, 2, 1'b0, 1'b0, 1);
        check_writes("type02");
        expect_record(16'h0020, 8'h00, 0, 1'b0);
        send_record(16'h0020, 8'h00, 0, 1'b0, 1'b0, 1);
        check_writes("len0");

        // Random records.
        for (int k = 0; k < 40; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            rn = $urandom_range(0, 8);
            rt = ($urandom_range(0, 5) == 0) ? 8'h04 : 8'h00;
            rb = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < rn; i++) rec[i] = 8'($urandom);
            expect_record(ra, rt, rn, rb);
            send_record(ra, rt, rn, rb, 1'($urandom), 2);
            check_writes("rand");
            if (exp_err) c0_pulse();
        end

        // Start a record, freeze it across a full dump with EN hammered, then finish it.
        send_str(":02010000AA");
        expect_wr(16'h0100, 8'hAA);
        DUMP_RAM = 1'b1;
        EN  = 1'b1;
        CHR = "G";
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            chk("dump_addr", ADDR, i);
            chk("dump_data", DATA, model_ram[i]);
            chk("dump_wr", WR, 1'b0);
        end
        repeat (3) begin
            @(negedge CLK);
            chk("dump_hold_top", ADDR, DEPTH - 1);
        end
        chk("dump_err", ERR, 1'b0);
        DUMP_RAM = 1'b0;
        EN  = 1'b0;
        CHR = 8'h00;
        @(negedge CLK);
        chk("post_dump_addr", ADDR, DEPTH - 1);
        chk("post_dump_data", DATA, model_ram[DEPTH-1]);
        send_str("55FE");
        expect_wr(16'h0101, 8'h55);
        check_writes("resume");

        // Second dump restarts at 0; reset mid-dump clears outputs at once.
        DUMP_RAM = 1'b1;
        repeat (100) @(negedge CLK);
        chk("dump2_addr", ADDR, 99);
        chk("dump2_data", DATA, model_ram[99]);
        #1 CLR = 1'b0;
        #1;
        chk("clr_addr", ADDR, 16'h0000);
        chk("clr_data", DATA, 8'h00);
        chk("clr_wr", WR, 1'b0);
        chk("clr_err", ERR, 1'b0);
        DUMP_RAM = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        obs_q.delete();
        rec[0] = 8'hE7;
        expect_record(16'h0200, 8'h00, 1, 1'b0);
        send_record(16'h0200, 8'h00, 1, 1'b0, 1'b0, 1);
        check_writes("after_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_ram.md
Name: hex_ram

Overview:
- Intel-HEX loader: consumes an ASCII character stream, one character per EN strobe.
- Parses records and writes each data byte into an internal byte RAM, presenting every write on WR/ADDR/DATA.
- Verifies the record checksum and flags format or checksum errors on ERR.
- After loading, DUMP_RAM sweeps the RAM out on ADDR/DATA. Sits between a character source (UART/file reader) and a memory image consumer.

Parameters:
RAM_AW, 10, internal RAM address width; depth 2**RAM_AW bytes; write addresses at or above the depth are not stored but still reported on WR/ADDR/DATA.

Ports:
CLK  input  1  system clock, all logic on rising edge
CLR  input  1  asynchronous, active-low reset
EN  input  1  character strobe; CHR valid when high, one character per high cycle
C0  input  1  synchronous error clear / parser restart
DUMP_RAM  input  1  level; high = sequential RAM dump mode
CHR  input  8  ASCII character
WR  output  1  one-cycle write pulse for a parsed data byte
ERR  output  1  sticky error flag
ADDR  output  16  write address (load mode) or dump address (dump mode)
DATA  output  8  written byte (load mode) or RAM contents (dump mode)

Behaviour:
- Reset (CLR=0, async): WR=0, ERR=0, ADDR=0, DATA=0, parser in IDLE, dump counter 0. RAM contents are not cleared.
- Hex digits accepted: 0-9, A-F, a-f. Each byte is two nibbles, high first.
- Record format: ':' LL AAAA TT DD×LL CC.
- Parser states:
  - IDLE: waits for ':'. All other characters, including CR, LF and spaces, are ignored.
  - LEN: 2 nibbles.
  - ADR: 4 nibbles, big-endian.
  - TYPE: 2 nibbles.
  - DATA: 2×LL nibbles; skipped when LL=0.
  - CSUM: 2 nibbles.
  - After CSUM, returns to IDLE. For type 01 with a good checksum, goes to DONE instead.
  - DONE: ignores all characters until reset or C0.
  - ERROR: entered on any non-hex character inside a record or on a checksum mismatch. Sets ERR=1, ignores input, waits for C0 or reset.
- Checksum: 8-bit sum of LL, both address bytes, TT, all data bytes and CC must be 0x00. It is checked on the cycle after the last CC nibble strobe.
- Data write:
  - Applies to type 00 only.
  - On the clock edge after the EN cycle carrying the low nibble of data byte i: WR=1 for exactly one cycle, ADDR=AAAA+i (16-bit wrap), DATA=byte.
  - The RAM is written at the same edge when ADDR < 2**RAM_AW.
  - Bytes are written before the checksum is verified. A later ERR does not roll them back.
  - Types other than 00 and 01 are parsed and checksummed with no WR.
- ADDR and DATA hold their last values between writes.
- C0=1 (synchronous): ERR←0, parser→IDLE, partial record discarded. C0 has priority over EN in the same cycle.
- Dump mode (DUMP_RAM=1):
  - Overrides parsing; EN is ignored and parser state is frozen.
  - Rising edge of DUMP_RAM restarts the counter at 0.
  - Each cycle: ADDR=counter, DATA=RAM[counter], with DATA aligned to ADDR in the same cycle (sync-read RAM, address pipelined by one).
  - The counter stops and holds at 2**RAM_AW-1.
  - WR=0 throughout. ERR is unaffected.
  - On DUMP_RAM falling, ADDR/DATA hold and parsing resumes from the frozen state.
- EN high for more than one cycle consumes CHR once per cycle.
- Reset mid-record discards the record. Bytes already written stay in RAM.

Test Plan:
- Reset held, then released; EN strobes of "G" and CR/LF while in IDLE -> WR=0, ERR=0, ADDR=0, DATA=0 throughout.
- Stream ":0300300002337A1E" -> three WR pulses with ADDR/DATA = 0x0030/0x02, 0x0031/0x33, 0x0032/0x7A; ERR stays 0.
- ":0300300002337A1F" -> same three writes, then ERR=1 one cycle after final 'F'. A following valid record produces no WR. C0 pulse -> ERR=0, and the next valid record writes normally.
- ":00000001FF" -> no WR, DONE reached; subsequent valid data records are ignored. Repeat with lowercase hex digits -> accepted identically.
- Non-hex 'G' inside the ADR field -> ERR=1, no WR.
- Load "0x02,0x33,0x7A at 0x0030", then DUMP_RAM=1 -> ADDR counts 0..1023 one per cycle, ADDR 0x0030..0x0032 show DATA 0x02,0x33,0x7A, WR=0. CLR pulsed low mid-dump -> outputs 0 immediately.
